// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute sequencer for the DRFA datapath.
// Drives PC, IR, register-file, ALU, memory-bank-selector and data-memory
// strobes from registered state, step and the current IR opcode.
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_ir              current IR contents (opcode in the top OPCODE_W bits)
//   in_alu_flags       ALU flags used by conditional jumps
//   in_mem_ready       data memory completes the pending access this cycle
//   out_*              datapath strobes, out_alu_op, out_halted, out_fault
module control_sequencer #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned FLAGS_W  = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] in_ir,
  input  logic [FLAGS_W-1:0] in_alu_flags,
  input  logic               in_mem_ready,
  output logic               out_pc_enable_out,
  output logic               out_pc_inc,
  output logic               out_pc_load,
  output logic               out_ir_load,
  output logic               out_ir_enable_read,
  output logic               out_reg_read_en,
  output logic               out_reg_write_en,
  output logic               out_alu_enable_out,
  output logic [2:0]         out_alu_op,
  output logic               out_mbs_wr_enable,
  output logic               out_data_memory_addr_wr_enable,
  output logic               out_data_memory_read_enable,
  output logic               out_data_memory_wr_enable,
  output logic               out_halted,
  output logic               out_fault
);

  localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    FETCH0,
    FETCH1,
    DECODE,
    EXEC,
    HALT
  } state_e;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_MEM  = 2'b01;
  localparam logic [1:0] CLS_JUMP = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          step_q, step_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic                fault_q, fault_d;

  logic [OPCODE_W-1:0] opcode;
  logic [1:0]          op_class;
  logic                is_nop;
  logic                is_halt_op;
  logic                is_store;
  logic                flag_sel;
  logic                jump_taken;
  logic                unused_ir;

  assign opcode     = in_ir[INSTR_W-1 -: OPCODE_W];
  assign op_class   = opcode[OPCODE_W-1 -: 2];
  assign is_nop     = (opcode == '0);
  assign is_halt_op = (opcode == '1);
  assign is_store   = opcode[0];
  assign unused_ir  = ^in_ir[INSTR_W-OPCODE_W-1:0];

  // Flag indices beyond FLAGS_W read as 0, so 10_111 jumps unconditionally
  // when FLAGS_W < 4.
  always_comb begin
    flag_sel = 1'b0;
    for (int unsigned i = 0; i < FLAGS_W; i++) begin
      if (i == 32'(opcode[1:0])) flag_sel = in_alu_flags[i];
    end
  end

  assign jump_taken = flag_sel ^ opcode[2];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    unique case (state_q)
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = DECODE;
      DECODE: begin
        step_d = '0;
        if (is_nop)          state_d = FETCH0;
        else if (is_halt_op) state_d = HALT;
        else                 state_d = EXEC;
      end
      EXEC: begin
        unique case (op_class)
          CLS_ALU: begin
            if (step_q == 2'd0) begin
              step_d = 2'd1;
            end else begin
              state_d = FETCH0;
              step_d  = '0;
            end
          end
          CLS_MEM: begin
            if (step_q == 2'd0) begin
              step_d = 2'd1;
            end else if (step_q == 2'd1) begin
              // Wait step: hold until ready, or give up after WAIT_MAX
              // consecutive not-ready cycles.
              if (in_mem_ready) begin
                wait_d = '0;
                if (is_store) begin
                  state_d = FETCH0;
                  step_d  = '0;
                end else begin
                  step_d = 2'd2;
                end
              end else if (wait_q == WAIT_LAST) begin
                state_d = HALT;
                fault_d = 1'b1;
                wait_d  = '0;
              end else begin
                wait_d = wait_q + 1'b1;
              end
            end else begin
              state_d = FETCH0;
              step_d  = '0;
            end
          end
          default: begin
            state_d = FETCH0;
            step_d  = '0;
          end
        endcase
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH0;
      step_q  <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Outputs decode registered state only; rst_n gates them so they are 0
  // for the whole time reset is held, not just after the next edge.
  always_comb begin
    out_pc_enable_out              = 1'b0;
    out_pc_inc                     = 1'b0;
    out_pc_load                    = 1'b0;
    out_ir_load                    = 1'b0;
    out_ir_enable_read             = 1'b0;
    out_reg_read_en                = 1'b0;
    out_reg_write_en               = 1'b0;
    out_alu_enable_out             = 1'b0;
    out_alu_op                     = '0;
    out_mbs_wr_enable              = 1'b0;
    out_data_memory_addr_wr_enable = 1'b0;
    out_data_memory_read_enable    = 1'b0;
    out_data_memory_wr_enable      = 1'b0;
    out_halted                     = 1'b0;
    out_fault                      = 1'b0;
    if (rst_n) begin
      out_fault = fault_q;
      unique case (state_q)
        FETCH0: out_pc_enable_out = 1'b1;
        FETCH1: begin
          out_ir_load = 1'b1;
          out_pc_inc  = 1'b1;
        end
        EXEC: begin
          unique case (op_class)
            CLS_ALU: begin
              if (step_q == 2'd0) begin
                out_reg_read_en    = 1'b1;
                out_alu_enable_out = 1'b1;
                out_alu_op         = opcode[2:0];
              end else begin
                out_reg_write_en = 1'b1;
              end
            end
            CLS_MEM: begin
              if (is_store) begin
                if (step_q == 2'd0) begin
                  out_data_memory_addr_wr_enable = 1'b1;
                end else begin
                  out_reg_read_en           = 1'b1;
                  out_data_memory_wr_enable = 1'b1;
                end
              end else begin
                if (step_q == 2'd0) begin
                  out_reg_read_en                = 1'b1;
                  out_data_memory_addr_wr_enable = 1'b1;
                end else if (step_q == 2'd1) begin
                  out_data_memory_read_enable = 1'b1;
                end else begin
                  out_reg_write_en = 1'b1;
                end
              end
            end
            CLS_JUMP: begin
              if (jump_taken) begin
                out_pc_load        = 1'b1;
                out_ir_enable_read = 1'b1;
              end
            end
            default: begin
              out_mbs_wr_enable  = 1'b1;
              out_ir_enable_read = 1'b1;
            end
          endcase
        end
        HALT:    out_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  // Observed vector bit layout:
  // 16 pc_en 15 pc_inc 14 pc_load 13 ir_load 12 ir_rd 11 reg_rd 10 reg_wr
  // 9 alu_en 8:6 alu_op 5 mbs 4 dm_addr 3 dm_rd 2 dm_wr 1 halted 0 fault
  localparam logic [16:0] PE   = 17'h10000;
  localparam logic [16:0] PI   = 17'h08000;
  localparam logic [16:0] PL   = 17'h04000;
  localparam logic [16:0] IL   = 17'h02000;
  localparam logic [16:0] IER  = 17'h01000;
  localparam logic [16:0] RR   = 17'h00800;
  localparam logic [16:0] RW   = 17'h00400;
  localparam logic [16:0] AE   = 17'h00200;
  localparam logic [16:0] AOP3 = 17'h000C0;
  localparam logic [16:0] AOP5 = 17'h00140;
  localparam logic [16:0] MBS  = 17'h00020;
  localparam logic [16:0] DA   = 17'h00010;
  localparam logic [16:0] DR   = 17'h00008;
  localparam logic [16:0] DW   = 17'h00004;
  localparam logic [16:0] HL   = 17'h00002;
  localparam logic [16:0] FT   = 17'h00001;
  localparam logic [16:0] Z    = 17'h00000;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_ir;
  logic [3:0]  in_alu_flags;
  logic        in_mem_ready;
  logic        pc_en, pc_inc, pc_load, ir_load, ir_rd, reg_rd, reg_wr, alu_en;
  logic [2:0]  alu_op;
  logic        mbs, dm_addr, dm_rd, dm_wr, halted, fault;
  logic [16:0] obs;

  control_sequencer #(
    .INSTR_W (16),
    .OPCODE_W(5),
    .FLAGS_W (4),
    .WAIT_MAX(15)
  ) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .in_ir                         (in_ir),
    .in_alu_flags                  (in_alu_flags),
    .in_mem_ready                  (in_mem_ready),
    .out_pc_enable_out             (pc_en),
    .out_pc_inc                    (pc_inc),
    .out_pc_load                   (pc_load),
    .out_ir_load                   (ir_load),
    .out_ir_enable_read            (ir_rd),
    .out_reg_read_en               (reg_rd),
    .out_reg_write_en              (reg_wr),
    .out_alu_enable_out            (alu_en),
    .out_alu_op                    (alu_op),
    .out_mbs_wr_enable             (mbs),
    .out_data_memory_addr_wr_enable(dm_addr),
    .out_data_memory_read_enable   (dm_rd),
    .out_data_memory_wr_enable     (dm_wr),
    .out_halted                    (halted),
    .out_fault                     (fault)
  );

  assign obs = {pc_en, pc_inc, pc_load, ir_load, ir_rd, reg_rd, reg_wr, alu_en,
                alu_op, mbs, dm_addr, dm_rd, dm_wr, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [4:0]       op;
    logic [3:0]       flags;
    logic [7:0]       rdy;
    int unsigned      len;
    logic [7:0][16:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [16:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic add(input string n, input logic [4:0] op, input logic [3:0] fl,
                     input logic [7:0] rdy, input int unsigned len,
                     input logic [16:0] e0, input logic [16:0] e1,
                     input logic [16:0] e2, input logic [16:0] e3,
                     input logic [16:0] e4, input logic [16:0] e5,
                     input logic [16:0] e6, input logic [16:0] e7);
    vec_t v;
    v.name = n; v.op = op; v.flags = fl; v.rdy = rdy; v.len = len;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string n, input int unsigned cyc, input logic [16:0] e);
    sb_t s;
    s.name = n; s.cyc = cyc; s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic check_pop();
    sb_t s;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %h want <queued entry>", obs);
    end else begin
      s = sb_q.pop_front();
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL %s cyc%0d: got %h want %h", s.name, s.cyc, obs, s.exp);
      end
    end
  endtask

  // Called just after a rising edge: drive inputs, sample at the falling edge.
  task automatic run_cycle(input string n, input int unsigned cyc,
                           input logic [16:0] e, input logic rdy);
    in_mem_ready = rdy;
    push_exp(n, cyc, e);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_pulse(input string n);
    rst_n = 1'b0;
    #2;
    push_exp({n, "_rst_async"}, 0, Z);
    check_pop();
    @(posedge clk);
    #1;
    push_exp({n, "_rst_held"}, 0, Z);
    check_pop();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned c;
    rst_n        = 1'b0;
    in_ir        = '0;
    in_alu_flags = '0;
    in_mem_ready = 1'b0;

    add("nop",        5'b00000, 4'h0, 8'hFF, 3, PE, PI|IL, Z, Z, Z, Z, Z, Z);
    add("nop_nordy",  5'b00000, 4'h0, 8'h00, 3, PE, PI|IL, Z, Z, Z, Z, Z, Z);
    add("alu3",       5'b00011, 4'h0, 8'hFF, 5, PE, PI|IL, Z, RR|AE|AOP3, RW, Z, Z, Z);
    add("alu5",       5'b00101, 4'hF, 8'h00, 5, PE, PI|IL, Z, RR|AE|AOP5, RW, Z, Z, Z);
    add("load",       5'b01000, 4'h0, 8'hFF, 6, PE, PI|IL, Z, RR|DA, DR, RW, Z, Z);
    add("load_w1",    5'b01000, 4'h0, 8'hE7, 7, PE, PI|IL, Z, RR|DA, DR, DR, RW, Z);
    add("store",      5'b01001, 4'h0, 8'hFF, 5, PE, PI|IL, Z, DA, RR|DW, Z, Z, Z);
    add("store_w3",   5'b01001, 4'h0, 8'h8F, 8, PE, PI|IL, Z, DA, RR|DW, RR|DW, RR|DW, RR|DW);
    add("jset1_t",    5'b10001, 4'b0010, 8'hFF, 4, PE, PI|IL, Z, PL|IER, Z, Z, Z, Z);
    add("jset1_nt",   5'b10001, 4'b0000, 8'hFF, 4, PE, PI|IL, Z, Z, Z, Z, Z, Z);
    add("jclr1_nt",   5'b10101, 4'b0010, 8'hFF, 4, PE, PI|IL, Z, Z, Z, Z, Z, Z);
    add("jclr1_t",    5'b10101, 4'b0000, 8'hFF, 4, PE, PI|IL, Z, PL|IER, Z, Z, Z, Z);
    add("jset3_t",    5'b10011, 4'b1000, 8'hFF, 4, PE, PI|IL, Z, PL|IER, Z, Z, Z, Z);
    add("jclr2_t",    5'b10110, 4'b1011, 8'hFF, 4, PE, PI|IL, Z, PL|IER, Z, Z, Z, Z);
    add("jset0_nt",   5'b10000, 4'b1110, 8'hFF, 4, PE, PI|IL, Z, Z, Z, Z, Z, Z);
    add("mbs0",       5'b11000, 4'h0, 8'hFF, 4, PE, PI|IL, Z, MBS|IER, Z, Z, Z, Z);
    add("mbs6",       5'b11110, 4'h0, 8'hFF, 4, PE, PI|IL, Z, MBS|IER, Z, Z, Z, Z);

    repeat (3) @(posedge clk);
    push_exp("reset", 0, Z);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      in_ir        = {vecs[i].op, 11'h2A5};
      in_alu_flags = vecs[i].flags;
      for (int unsigned k = 0; k < vecs[i].len; k++)
        run_cycle(vecs[i].name, k, vecs[i].exp[k], vecs[i].rdy[k]);
    end

    // Store that never sees ready: 15 wait cycles, then HALT with fault.
    in_ir        = {5'b01001, 11'h155};
    in_alu_flags = '0;
    run_cycle("tmo", 0, PE, 1'b0);
    run_cycle("tmo", 1, PI|IL, 1'b0);
    run_cycle("tmo", 2, Z, 1'b0);
    run_cycle("tmo", 3, DA, 1'b0);
    c = 4;
    for (int unsigned k = 0; k < 15; k++) begin
      run_cycle("tmo_wait", c, RR|DW, 1'b0);
      c++;
    end
    for (int unsigned k = 0; k < 3; k++) begin
      run_cycle("tmo_halt", c, HL|FT, 1'b1);
      c++;
    end
    async_reset_pulse("tmo");
    in_ir = '0;
    run_cycle("tmo_resume", 0, PE, 1'b0);
    run_cycle("tmo_resume", 1, PI|IL, 1'b0);
    run_cycle("tmo_resume", 2, Z, 1'b0);
    run_cycle("tmo_resume", 3, PE, 1'b0);

    // HALT opcode: stays halted until reset, fault stays clear.
    in_ir = {5'b11111, 11'h000};
    run_cycle("halt", 0, PI|IL, 1'b1);
    run_cycle("halt", 1, Z, 1'b1);
    for (int unsigned k = 0; k < 20; k++)
      run_cycle("halt_hold", k, HL, k[0]);
    async_reset_pulse("halt");
    in_ir = '0;
    run_cycle("halt_resume", 0, PE, 1'b1);
    run_cycle("halt_resume", 1, PI|IL, 1'b1);
    run_cycle("halt_resume", 2, Z, 1'b1);

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
